// File: rtl/dm1_5_reg_if.sv
// -----------------------------------------------------------------------------
// dm1_5_reg_if : bus bundle for the registered 1-to-5 demultiplexer.
//   master : write-back bus side plus consumers (drives i/s/en/ack)
//   slave  : the demux itself (drives holding registers and status)
// Optional feature macro: DM_ERRCNT_EN adds the errcnt illegal-select counter.
// -----------------------------------------------------------------------------
interface dm1_5_reg_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] i;
    logic [2:0]       s;
    logic             en;
    logic [4:0]       ack;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic [WIDTH-1:0] o3;
    logic [WIDTH-1:0] o4;
    logic [4:0]       v;
    logic             ovr;
    logic             err;
`ifdef DM_ERRCNT_EN
    logic [7:0]       errcnt;
`endif

    modport master (
        output i, s, en, ack,
        input  o0, o1, o2, o3, o4, v, ovr, err
`ifdef DM_ERRCNT_EN
        , input errcnt
`endif
    );

    modport slave (
        input  i, s, en, ack,
        output o0, o1, o2, o3, o4, v, ovr, err
`ifdef DM_ERRCNT_EN
        , output errcnt
`endif
    );
endinterface

// File: rtl/dm1_5_reg.sv
// -----------------------------------------------------------------------------
// dm1_5_reg : registered 1-to-5 demultiplexer with per-destination valid flags.
//   One write-back value is steered into one of five holding registers; each
//   destination's consumer clears its valid flag with ack. Overwriting unconsumed
//   data sets sticky ovr; selects 5..7 set sticky err and change nothing else.
//   All outputs come straight from flops. Synchronous active-high reset.
// Optional feature macro: DM_ERRCNT_EN adds an 8-bit saturating count of
//   illegal selects (errcnt); without it err alone flags them.
// -----------------------------------------------------------------------------
module dm1_5_reg #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    dm1_5_reg_if.slave     bus
);
    logic [WIDTH-1:0] o_q [5];
    logic [4:0]       v_q;
    logic             ovr_q;
    logic             err_q;

    logic [4:0]       wr_hit;
    logic             illegal;
    logic             overrun;
    logic [4:0]       v_next;

    // Decode the select into a one-hot write strobe and detect illegal selects.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_hit  = '0;
        illegal = 1'b0;
        if (bus.en) begin
            case (bus.s)
                3'd0:    wr_hit = 5'b00001;
                3'd1:    wr_hit = 5'b00010;
                3'd2:    wr_hit = 5'b00100;
                3'd3:    wr_hit = 5'b01000;
                3'd4:    wr_hit = 5'b10000;
                default: illegal = 1'b1;
            endcase
        end
        // A write on the same edge as its ack wins: old data counts as consumed.
        overrun = |(wr_hit & v_q & ~bus.ack);
        v_next  = (v_q & ~bus.ack) | wr_hit;
    end

    // Holding registers, valid flags and sticky status; reset discards any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the five holding registers are architecturally visible and must read 0 after reset, so they are reset (unlike a RAM).
            for (int k = 0; k < 5; k++) o_q[k] <= '0;
            v_q   <= '0;
            ovr_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            for (int k = 0; k < 5; k++) begin
                if (wr_hit[k]) o_q[k] <= bus.i;
            end
            v_q <= v_next;
            if (overrun) ovr_q <= 1'b1;
            if (illegal) err_q <= 1'b1;
        end
    end

`ifdef DM_ERRCNT_EN
    logic [7:0] errcnt_q;

    // Saturating count of illegal selects; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            errcnt_q <= '0;
        end else if (illegal && errcnt_q != 8'hFF) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign bus.errcnt = errcnt_q;
`endif

    assign bus.o0  = o_q[0];
    assign bus.o1  = o_q[1];
    assign bus.o2  = o_q[2];
    assign bus.o3  = o_q[3];
    assign bus.o4  = o_q[4];
    assign bus.v   = v_q;
    assign bus.ovr = ovr_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_dm1_5_reg.sv
// -----------------------------------------------------------------------------
// tb_dm1_5_reg : self-checking bench for dm1_5_reg.
//   Directed scenarios use literal expected values; a randomized run is checked
//   against a behavioural model (arrays of destination data and valid bits).
// Optional feature macro: DM_ERRCNT_EN enables errcnt checks.
// -----------------------------------------------------------------------------
module tb_dm1_5_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    dm1_5_reg_if #(.WIDTH(16)) bus ();

    dm1_5_reg #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural reference state
    logic [15:0] m_o [5];
    logic [4:0]  m_v;
    logic        m_ovr;
    logic        m_err;
    int          m_cnt;

    function automatic logic [15:0] dut_o(input int k);
        case (k)
            0:       return bus.o0;
            1:       return bus.o1;
            2:       return bus.o2;
            3:       return bus.o3;
            default: return bus.o4;
        endcase
    endfunction

    function automatic int dut_cnt();
`ifdef DM_ERRCNT_EN
        return int'(bus.errcnt);
`else
        return m_cnt;
`endif
    endfunction

    // Apply one cycle of stimulus, advance the model, then settle past the edge.
    task automatic drive(input logic r, input logic e, input logic [2:0] sel,
                         input logic [15:0] d, input logic [4:0] a);
        logic [4:0] nv;
        @(negedge clk);
        rst = r; bus.en = e; bus.s = sel; bus.i = d; bus.ack = a;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 5; k++) m_o[k] = '0;
            m_v = '0; m_ovr = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            nv = m_v & ~a;
            if (e && sel <= 3'd4) begin
                if (m_v[sel] && !a[sel]) m_ovr = 1'b1;
                m_o[sel] = d;
                nv[sel] = 1'b1;
            end else if (e) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
            m_v = nv;
        end
        #1;
        rst = 1'b0; bus.en = 1'b0; bus.ack = '0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 3'd0, 16'hFFFF, 5'b00000);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (dut_o(k) !== 16'h0000) begin
                bad++; $display("FAIL reset_o%0d: got %h want 0000", k, dut_o(k));
            end
        end
        total++;
        if (bus.v !== 5'b00000) begin bad++; $display("FAIL reset_v: got %b want 00000", bus.v); end
        total++;
        if (bus.ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", bus.ovr); end
        total++;
        if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
`ifdef DM_ERRCNT_EN
        total++;
        if (bus.errcnt !== 8'd0) begin bad++; $display("FAIL reset_errcnt: got %0d want 0", bus.errcnt); end
`endif
    endtask

    task automatic test_fill_ack();
        logic [15:0] vals [5];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        vals[3] = 16'h4444; vals[4] = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 3'(k), vals[k], 5'b00000);
            total++;
            if (dut_o(k) !== vals[k]) begin
                bad++; $display("FAIL fill_o%0d: got %h want %h", k, dut_o(k), vals[k]);
            end
        end
        total++;
        if (bus.v !== 5'b11111) begin bad++; $display("FAIL fill_v: got %b want 11111", bus.v); end
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 5'b11111);
        total++;
        if (bus.v !== 5'b00000) begin bad++; $display("FAIL ack_v: got %b want 00000", bus.v); end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (dut_o(k) !== vals[k]) begin
                bad++; $display("FAIL ack_keep_o%0d: got %h want %h", k, dut_o(k), vals[k]);
            end
        end
        total++;
        if (bus.ovr !== 1'b0) begin bad++; $display("FAIL fill_ovr: got %b want 0", bus.ovr); end
    endtask

    task automatic test_overrun();
        drive(1'b0, 1'b1, 3'd2, 16'hABCD, 5'b00000);
        total++;
        if (bus.v[2] !== 1'b1) begin bad++; $display("FAIL ovr_v2: got %b want 1", bus.v[2]); end
        total++;
        if (bus.ovr !== 1'b0) begin bad++; $display("FAIL ovr_pre: got %b want 0", bus.ovr); end
        drive(1'b0, 1'b1, 3'd2, 16'h1234, 5'b00000);
        total++;
        if (bus.o2 !== 16'h1234) begin bad++; $display("FAIL ovr_o2: got %h want 1234", bus.o2); end
        total++;
        if (bus.ovr !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", bus.ovr); end
        // Reset with a write pending: write must be discarded
        drive(1'b1, 1'b1, 3'd1, 16'h7777, 5'b00000);
        total++;
        if (bus.ovr !== 1'b0) begin bad++; $display("FAIL ovr_rst: got %b want 0", bus.ovr); end
        total++;
        if (bus.o1 !== 16'h0000 || bus.v !== 5'b00000) begin
            bad++; $display("FAIL rst_discard: got o1=%h v=%b want 0000/00000", bus.o1, bus.v);
        end
    endtask

    task automatic test_write_ack();
        drive(1'b0, 1'b1, 3'd3, 16'h0F0F, 5'b00000);
        drive(1'b0, 1'b1, 3'd3, 16'hBEEF, 5'b01000);
        total++;
        if (bus.o3 !== 16'hBEEF) begin bad++; $display("FAIL wack_o3: got %h want beef", bus.o3); end
        total++;
        if (bus.v[3] !== 1'b1) begin bad++; $display("FAIL wack_v3: got %b want 1", bus.v[3]); end
        total++;
        if (bus.ovr !== 1'b0) begin bad++; $display("FAIL wack_ovr: got %b want 0", bus.ovr); end
    endtask

    task automatic test_illegal();
        logic [15:0] o_before [5];
        logic [4:0]  v_before;
        for (int k = 0; k < 5; k++) o_before[k] = dut_o(k);
        v_before = bus.v;
        total++;
        if (bus.err !== 1'b0) begin bad++; $display("FAIL ill_pre_err: got %b want 0", bus.err); end
        for (int n = 5; n < 8; n++) drive(1'b0, 1'b1, 3'(n), 16'hDEAD, 5'b00000);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (dut_o(k) !== o_before[k]) begin
                bad++; $display("FAIL ill_o%0d: got %h want %h", k, dut_o(k), o_before[k]);
            end
        end
        total++;
        if (bus.v !== v_before) begin bad++; $display("FAIL ill_v: got %b want %b", bus.v, v_before); end
        total++;
        if (bus.err !== 1'b1) begin bad++; $display("FAIL ill_err: got %b want 1", bus.err); end
`ifdef DM_ERRCNT_EN
        total++;
        if (bus.errcnt !== 8'd3) begin bad++; $display("FAIL ill_errcnt: got %0d want 3", bus.errcnt); end
`endif
        // Illegal select with a simultaneous ack: the ack is still honoured
        drive(1'b0, 1'b1, 3'd6, 16'hDEAD, 5'b01000);
        total++;
        if (bus.v[3] !== 1'b0) begin bad++; $display("FAIL ill_ack_v3: got %b want 0", bus.v[3]); end
    endtask

`ifdef DM_ERRCNT_EN
    task automatic test_saturate();
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 5'b00000);
        for (int n = 0; n < 300; n++) drive(1'b0, 1'b1, 3'd7, 16'h0000, 5'b00000);
        total++;
        if (bus.errcnt !== 8'd255) begin bad++; $display("FAIL sat_errcnt: got %0d want 255", bus.errcnt); end
        total++;
        if (bus.err !== 1'b1) begin bad++; $display("FAIL sat_err: got %b want 1", bus.err); end
    endtask
`endif

    task automatic test_random();
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 5'b00000);
        for (int n = 0; n < 600; n++) begin
            logic       r;
            logic       e;
            logic [2:0] sel;
            logic [4:0] a;
            r   = ($urandom_range(0, 59) == 0);
            e   = ($urandom_range(0, 3) != 0);
            sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            a   = 5'($urandom) & 5'($urandom);
            drive(r, e, sel, 16'($urandom), a);
            for (int k = 0; k < 5; k++) begin
                total++;
                if (dut_o(k) !== m_o[k]) begin
                    bad++; $display("FAIL rnd_o%0d cyc %0d: got %h want %h", k, n, dut_o(k), m_o[k]);
                end
            end
            total++;
            if (bus.v !== m_v) begin bad++; $display("FAIL rnd_v cyc %0d: got %b want %b", n, bus.v, m_v); end
            total++;
            if (bus.ovr !== m_ovr) begin bad++; $display("FAIL rnd_ovr cyc %0d: got %b want %b", n, bus.ovr, m_ovr); end
            total++;
            if (bus.err !== m_err) begin bad++; $display("FAIL rnd_err cyc %0d: got %b want %b", n, bus.err, m_err); end
`ifdef DM_ERRCNT_EN
            total++;
            if (dut_cnt() !== m_cnt) begin bad++; $display("FAIL rnd_errcnt cyc %0d: got %0d want %0d", n, dut_cnt(), m_cnt); end
`endif
        end
    endtask

    initial begin
        bus.i = '0; bus.s = '0; bus.en = 1'b0; bus.ack = '0;
        for (int k = 0; k < 5; k++) m_o[k] = '0;
        m_v = '0; m_ovr = 1'b0; m_err = 1'b0; m_cnt = 0;
        test_reset();
        test_fill_ack();
        test_overrun();
        test_write_ack();
        test_illegal();
`ifdef DM_ERRCNT_EN
        test_saturate();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
